// File: rtl/result_writeback_sequencer_if.sv
// Execute-stage result bundle: condition, flag update and up to two register results.
// master = execute stage driving a bundle, slave = writeback sequencer consuming it.
interface result_writeback_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            cond;
  logic                  set_flags;
  logic [3:0]            new_flags;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] wa1;
  logic [DATA_WIDTH-1:0] wd1;
  logic                  we2;
  logic [ADDR_WIDTH-1:0] wa2;
  logic [DATA_WIDTH-1:0] wd2;

  modport master (
    output in_valid, cond, set_flags, new_flags, we1, wa1, wd1, we2, wa2, wd2,
    input  in_ready
  );

  modport slave (
    input  in_valid, cond, set_flags, new_flags, we1, wa1, wd1, we2, wa2, wd2,
    output in_ready
  );
endinterface

// File: rtl/result_writeback_sequencer.sv
// Condition-checks execute results, commits NZCV and serialises up to two writes onto one RF port.
// Latency: first write and flag update 1 cycle after accept, second write at +2.
// Backpressure: in_ready low for the one cycle spent draining a buffered second write.
module result_writeback_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  result_writeback_sequencer_if.slave res,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wa,
  output logic [DATA_WIDTH-1:0] rf_wd,
  output logic [3:0]            flags,
  output logic                  cond_pass
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0] wd;
  } wr_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  wr_t        pend;
  wr_t        pend_nxt;
  wr_t        rf_nxt;
  logic       rf_we_nxt;
  logic [3:0] flags_nxt;
  logic       cond_pass_nxt;
  logic       pass;
  logic       accept;

  // Flags are {N,Z,C,V}; evaluated against the pre-update architectural value.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cc)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c & !z;
      4'b1001: r = !c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State-only ready keeps the handshake free of combinational loops.
  assign res.in_ready = (state == IDLE);
  assign pass         = cond_eval(res.cond, flags);
  assign accept       = (state == IDLE) && res.in_valid && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rf_we_nxt     = 1'b0;
    rf_nxt        = '{wa: rf_wa, wd: rf_wd};
    flags_nxt     = flags;
    cond_pass_nxt = 1'b0;
    pend_nxt      = pend;

    if (flush) begin
      state_nxt = IDLE;
      pend_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cond_pass_nxt = pass;
            if (pass && res.set_flags) begin
              flags_nxt = res.new_flags;
            end
            if (pass && res.we1) begin
              rf_we_nxt = 1'b1;
              rf_nxt    = '{wa: res.wa1, wd: res.wd1};
              if (res.we2) begin
                pend_nxt  = '{wa: res.wa2, wd: res.wd2};
                state_nxt = PEND;
              end
            end else if (pass && res.we2) begin
              rf_we_nxt = 1'b1;
              rf_nxt    = '{wa: res.wa2, wd: res.wd2};
            end
          end
        end
        PEND: begin
          rf_we_nxt = 1'b1;
          rf_nxt    = pend;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we     <= 1'b0;
      rf_wa     <= '0;
      rf_wd     <= '0;
      flags     <= 4'b0000;
      cond_pass <= 1'b0;
      pend      <= '0;
    end else begin
      rf_we     <= rf_we_nxt;
      rf_wa     <= rf_nxt.wa;
      rf_wd     <= rf_nxt.wd;
      flags     <= flags_nxt;
      cond_pass <= cond_pass_nxt;
      pend      <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_result_writeback_sequencer.sv
// Directed bench for result_writeback_sequencer; expected RF writes go through a scoreboard queue.
module tb_result_writeback_sequencer;

  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct packed {
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } exp_wr_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [3:0]    flags;
  logic          cond_pass;

  int checks = 0;
  int errors = 0;

  exp_wr_t    exp_q[$];
  logic [3:0] mflags;
  bit         mbusy;

  result_writeback_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rif ();

  result_writeback_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .res       (rif),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .flags     (flags),
    .cond_pass (cond_pass)
  );

  always #5 clk = ~clk;

  // Reference condition table, flags ordered {N,Z,C,V}.
  function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sampling on the falling edge; every RF write is matched against the queue.
  task automatic tick();
    exp_wr_t e;
    @(posedge clk);
    @(negedge clk);
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, rf_we}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {60'd0, rf_wa}, {60'd0, e.wa});
        chk("wr_data", {32'd0, rf_wd}, {32'd0, e.wd});
      end
    end
  endtask

  task automatic send(input logic [3:0] cc, input logic s, input logic [3:0] nf,
                      input logic e1, input logic [3:0] a1, input logic [31:0] d1,
                      input logic e2, input logic [3:0] a2, input logic [31:0] d2);
    bit p;
    rif.in_valid  = 1'b1;
    rif.cond      = cc;
    rif.set_flags = s;
    rif.new_flags = nf;
    rif.we1 = e1; rif.wa1 = a1; rif.wd1 = d1;
    rif.we2 = e2; rif.wa2 = a2; rif.wd2 = d2;
    if (mbusy) begin
      chk("in_ready_pend", {63'd0, rif.in_ready}, 64'd0);
      mbusy = 1'b0;
      tick();
      chk("cond_pass_pend", {63'd0, cond_pass}, 64'd0);
    end
    chk("in_ready_idle", {63'd0, rif.in_ready}, 64'd1);
    p = ref_cond(cc, mflags);
    if (p && e1) exp_q.push_back('{wa: a1, wd: d1});
    if (p && e2) exp_q.push_back('{wa: a2, wd: d2});
    if (p && s) mflags = nf;
    mbusy = p && e1 && e2;
    tick();
    chk("cond_pass", {63'd0, cond_pass}, {63'd0, p});
    chk("flags", {60'd0, flags}, {60'd0, mflags});
    chk("rf_we", {63'd0, rf_we}, {63'd0, p && (e1 || e2)});
  endtask

  task automatic idle(input int n);
    rif.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      mbusy = 1'b0;
      tick();
      chk("cond_pass_idle", {63'd0, cond_pass}, 64'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    rif.in_valid = 1'b0; rif.cond = 4'h0; rif.set_flags = 1'b0; rif.new_flags = 4'h0;
    rif.we1 = 1'b0; rif.wa1 = '0; rif.wd1 = '0;
    rif.we2 = 1'b0; rif.wa2 = '0; rif.wd2 = '0;
    mflags = 4'h0;
    mbusy  = 1'b0;
    #12;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_rf_wa", {60'd0, rf_wa}, 64'd0);
    chk("rst_rf_wd", {32'd0, rf_wd}, 64'd0);
    chk("rst_flags", {60'd0, flags}, 64'd0);
    chk("rst_cond_pass", {63'd0, cond_pass}, 64'd0);
    chk("rst_in_ready", {63'd0, rif.in_ready}, 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // ADDS R3: always-condition, flags set to Z
    send(4'hE, 1'b1, 4'b0100, 1'b1, 4'd3, 32'h5, 1'b0, 4'd0, 32'h0);
    idle(1);

    // Z=1: NE fails and must not touch flags, EQ then writes
    send(4'h1, 1'b1, 4'b1111, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0, 32'h0);
    send(4'h0, 1'b0, 4'b0000, 1'b1, 4'd2, 32'h23, 1'b0, 4'd0, 32'h0);

    // UMULL double write followed by a back-to-back single write
    send(4'hE, 1'b0, 4'b0000, 1'b1, 4'd5, 32'h1, 1'b1, 4'd4, 32'hFFFF_FFFE);
    send(4'hE, 1'b0, 4'b0000, 1'b1, 4'd9, 32'h99, 1'b0, 4'd0, 32'h0);
    // second-result-only write
    send(4'hE, 1'b0, 4'b0000, 1'b0, 4'd1, 32'h11, 1'b1, 4'd6, 32'h66);
    idle(1);

    // Full condition sweep: load flags, then a single conditional write
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        send(4'hE, 1'b1, 4'(f), 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        send(4'(c), 1'b0, 4'h0, 1'b1, 4'(c), {24'd0, 4'(c), 4'(f)}, 1'b0, 4'd0, 32'h0);
      end
    end
    idle(1);

    // Flush while the second write is buffered
    send(4'hE, 1'b1, 4'b1010, 1'b1, 4'd8, 32'h88, 1'b1, 4'd9, 32'h99);
    rif.in_valid = 1'b1;
    flush = 1'b1;
    if (mbusy) void'(exp_q.pop_back());
    mbusy = 1'b0;
    tick();
    flush = 1'b0;
    rif.in_valid = 1'b0;
    chk("flush_rf_we", {63'd0, rf_we}, 64'd0);
    chk("flush_cond_pass", {63'd0, cond_pass}, 64'd0);
    chk("flush_flags", {60'd0, flags}, {60'd0, mflags});
    chk("flush_in_ready", {63'd0, rif.in_ready}, 64'd1);
    idle(1);

    // Reset while the second write is buffered
    send(4'hE, 1'b1, 4'b0110, 1'b1, 4'd10, 32'hAA, 1'b1, 4'd11, 32'hBB);
    rif.in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("arst_rf_wa", {60'd0, rf_wa}, 64'd0);
    chk("arst_rf_wd", {32'd0, rf_wd}, 64'd0);
    chk("arst_flags", {60'd0, flags}, 64'd0);
    chk("arst_cond_pass", {63'd0, cond_pass}, 64'd0);
    chk("arst_in_ready", {63'd0, rif.in_ready}, 64'd1);
    exp_q.delete();
    mflags = 4'h0;
    mbusy  = 1'b0;
    #2;
    reset_n = 1'b1;
    idle(2);

    // Same destination twice: wd2 lands last; failing condition holds flags despite S
    send(4'hE, 1'b0, 4'b0000, 1'b1, 4'd7, 32'hA, 1'b1, 4'd7, 32'hB);
    idle(1);
    chk("same_dst_final", {32'd0, rf_wd}, 64'hB);
    send(4'hE, 1'b1, 4'b0001, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    send(4'hF, 1'b1, 4'b1110, 1'b1, 4'd7, 32'hC, 1'b0, 4'd0, 32'h0);
    idle(2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
